// File: rtl/ddfs_wave_gen.sv
// ddfs_wave_gen
//   Waveform synthesis stage fed by the frequency divider. Each rising edge
//   of tick_in is one sample tick. On an accepted tick the phase accumulator
//   advances by tuning_word. The new phase is then mapped to one of four
//   waveforms: saw, triangle, square or inverted saw.
//
// Ports
//   clk_in        system clock (same clock as the divider)
//   rst           synchronous reset, active-high
//   tick_in       divider square output; each 0->1 transition is one tick
//   enable        1 = ticks advance the phase, 0 = ticks ignored
//   phase_clr     synchronous phase clear; wins over a coincident tick
//   tuning_word   phase increment per tick (PHASE_W bits)
//   wave_sel      0 saw, 1 triangle, 2 square, 3 inverted saw
//   duty          square-wave threshold (OUT_W bits)
//   sample_out    registered waveform sample (OUT_W bits)
//   sample_valid  one-cycle strobe: sample_out is new
//   phase_wrap    one-cycle strobe with sample_valid: the accumulation that
//                 produced this sample carried out of the accumulator
module ddfs_wave_gen #(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               tick_in,
  input  logic               enable,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [1:0]         wave_sel,
  input  logic [OUT_W-1:0]   duty,
  output logic [OUT_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic               phase_wrap
);

  localparam logic [1:0] SEL_SAW  = 2'd0;
  localparam logic [1:0] SEL_TRI  = 2'd1;
  localparam logic [1:0] SEL_SQR  = 2'd2;

  // Stage 1 state
  logic               tick_q_reg;
  logic [PHASE_W-1:0] phase_reg;
  logic               carry_reg;
  logic               s1_valid_reg;
  logic [1:0]         wsel_reg;
  logic [OUT_W-1:0]   duty_reg;

  // Stage 2 state
  logic [OUT_W-1:0]   sample_reg;
  logic               valid_reg;
  logic               wrap_reg;

  logic               tick;
  logic [PHASE_W:0]   sum_next;
  logic [OUT_W-1:0]   p;
  logic [OUT_W-1:0]   s;
  logic [OUT_W-1:0]   tri_val;
  logic [OUT_W-1:0]   wave_next;

  // tick_q resets to 1 so a tick_in level held high through reset is not
  // mistaken for an edge.
  assign tick = tick_in & ~tick_q_reg;

  // One extra bit on the adder captures the carry-out for phase_wrap.
  assign sum_next = {1'b0, phase_reg} + {1'b0, tuning_word};

  always_ff @(posedge clk_in) begin
    if (rst) begin
      tick_q_reg   <= 1'b1;
      phase_reg    <= '0;
      carry_reg    <= 1'b0;
      s1_valid_reg <= 1'b0;
      wsel_reg     <= '0;
      duty_reg     <= '0;
    end else begin
      tick_q_reg <= tick_in;
      if (phase_clr) begin
        phase_reg    <= '0;
        s1_valid_reg <= 1'b0;
      end else if (tick && enable) begin
        phase_reg    <= sum_next[PHASE_W-1:0];
        carry_reg    <= sum_next[PHASE_W];
        s1_valid_reg <= 1'b1;
        // Waveform controls are captured with the tick so that a change
        // between ticks cannot disturb the sample in flight.
        wsel_reg     <= wave_sel;
        duty_reg     <= duty;
      end else begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  // Waveform mapping works on the top OUT_W bits of the phase.
  assign p = phase_reg[PHASE_W-1 -: OUT_W];
  assign s = {p[OUT_W-2:0], 1'b0};

  // Triangle: the rising half is 2p. The falling half is the bitwise
  // complement of 2p, so the MSB of p selects inversion bit by bit.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_tri
      assign tri_val[gi] = s[gi] ^ p[OUT_W-1];
    end
  endgenerate

  always_comb begin
    wave_next = ~p;
    case (wsel_reg)
      SEL_SAW: wave_next = p;
      SEL_TRI: wave_next = tri_val;
      SEL_SQR: wave_next = (p < duty_reg) ? {OUT_W{1'b1}} : '0;
      default: wave_next = ~p;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sample_reg <= '0;
      valid_reg  <= 1'b0;
      wrap_reg   <= 1'b0;
    end else begin
      valid_reg <= s1_valid_reg;
      wrap_reg  <= s1_valid_reg & carry_reg;
      if (s1_valid_reg) begin
        sample_reg <= wave_next;
      end
    end
  end

  assign sample_out   = sample_reg;
  assign sample_valid = valid_reg;
  assign phase_wrap   = wrap_reg;

endmodule

// File: tb/tb_ddfs_wave_gen.sv
// Testbench for ddfs_wave_gen. Stimulus drives tick levels and controls one
// cycle at a time. A reference model pushes an expected sample into a queue
// for every accepted tick. A negedge monitor pops and compares the entry
// whenever the DUT strobes sample_valid.
module tb_ddfs_wave_gen;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        tick_in;
  logic        enable;
  logic        phase_clr;
  logic [15:0] tuning_word;
  logic [1:0]  wave_sel;
  logic [7:0]  duty;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        phase_wrap;

  ddfs_wave_gen #(.PHASE_W(16), .OUT_W(8)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .tick_in     (tick_in),
    .enable      (enable),
    .phase_clr   (phase_clr),
    .tuning_word (tuning_word),
    .wave_sel    (wave_sel),
    .duty        (duty),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .phase_wrap  (phase_wrap)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int       due;
    bit [7:0] smp;
    bit       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int m_phase = 0;
  bit m_prev  = 1'b1;

  // Values the next step() call applies
  bit [15:0] tw_v   = 16'h0;
  bit [1:0]  ws_v   = 2'd0;
  bit [7:0]  duty_v = 8'h0;

  function automatic bit [7:0] wave_of(int ph, bit [1:0] ws, bit [7:0] d);
    int pv;
    pv = ph / 256;
    case (ws)
      2'd0: return 8'(pv);
      2'd1: return (pv < 128) ? 8'(2 * pv) : 8'(511 - 2 * pv);
      2'd2: return (pv < int'(d)) ? 8'd255 : 8'd0;
      default: return 8'(255 - pv);
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Apply one cycle of inputs and advance the reference model.
  task automatic step(input bit t, input bit en, input bit clr, input bit r);
    bit   tk;
    int   sum;
    exp_t e;
    @(posedge clk_in);
    #1;
    tick_in     = t;
    enable      = en;
    phase_clr   = clr;
    rst         = r;
    tuning_word = tw_v;
    wave_sel    = ws_v;
    duty        = duty_v;
    tk = t && !m_prev;
    m_prev = r ? 1'b1 : t;
    if (r) begin
      m_phase = 0;
      // Samples still in flight (due after this cycle) are lost.
      while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    end else if (clr) begin
      m_phase = 0;
    end else if (tk && en) begin
      sum = m_phase + int'(tw_v);
      e.wrap = (sum >= 65536);
      m_phase = sum % 65536;
      e.smp = wave_of(m_phase, ws_v, duty_v);
      e.due = cyc + 2;
      exp_q.push_back(e);
      $display("tick cyc=%0d ws=%0d tw=0x%04h duty=0x%02h -> exp sample=0x%02h wrap=%0d",
               cyc, ws_v, tw_v, duty_v, e.smp, e.wrap);
    end
  endtask

  // Monitor: compare every strobed sample against the scoreboard.
  always @(negedge clk_in) begin
    exp_t e;
    if (sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got sample_valid=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("latency", cyc, e.due);
        chk("sample_out", int'(sample_out), int'(e.smp));
        chk("phase_wrap", int'(phase_wrap), int'(e.wrap));
      end
    end else if (phase_wrap === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wrap_without_valid: got phase_wrap=1 expected=0 (cycle %0d)", cyc);
    end
  end

  initial begin
    rst = 1'b1; tick_in = 1'b1; enable = 1'b1; phase_clr = 1'b0;
    tuning_word = '0; wave_sel = '0; duty = '0;

    // 1: tick_in held high through and after reset gives no tick.
    tw_v = 16'h1000; ws_v = 2'd0;
    repeat (3) step(1, 1, 0, 1);
    repeat (4) step(1, 1, 0, 0);
    chk("reset_sample_out", int'(sample_out), 0);
    chk("reset_valid", int'(sample_valid), 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);

    // 2: saw ramp with tick toggling every cycle.
    step(0, 1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
    end

    // 3: triangle from phase 0.
    step(0, 1, 1, 0);
    tw_v = 16'h4000; ws_v = 2'd1;
    for (int i = 0; i < 4; i++) begin step(1, 1, 0, 0); step(0, 1, 0, 0); end

    // 4: square, duty 0x80, then duty 0 between ticks.
    step(0, 1, 1, 0);
    ws_v = 2'd2; duty_v = 8'h80;
    for (int i = 0; i < 4; i++) begin step(1, 1, 0, 0); step(0, 1, 0, 0); end
    duty_v = 8'h00;
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin step(1, 1, 0, 0); step(0, 1, 0, 0); end

    // 5: phase_clr coincident with a tick drops the tick.
    ws_v = 2'd0; tw_v = 16'h1000;
    step(1, 1, 1, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);

    // 6a: enable=0 across 3 ticks; phase held.
    for (int i = 0; i < 3; i++) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
    step(1, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    // 6b: rst in the cycle after an accepted tick suppresses the sample.
    step(1, 1, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    chk("rst_mid_sample_out", int'(sample_out), 0);
    chk("rst_mid_valid", int'(sample_valid), 0);
    repeat (3) step(0, 1, 0, 0);

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        tw_v = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        ws_v = 2'($urandom);
        duty_v = 8'($urandom);
      end
      step(1'($urandom),
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 49) == 0);
    end
    repeat (4) step(0, 1, 0, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
